// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add controller. Sequences one external full-adder cell over
//   WIDTH-bit operands, LSB first, one bit per clock, so a single cell does
//   the work of a WIDTH-bit ripple adder at the cost of WIDTH+1 cycles.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; operands captured on the accepting edge
//   CALC  | one operand bit per clock through the external cell
//   DONE  | result registered; done pulses for exactly this cycle
//
// Ports
//   clk              system clock, rising edge
//   rst_n            synchronous active-low reset
//   start            request, sampled only in IDLE (held high re-triggers)
//   din_a, din_b     operands, captured on an accepted start
//   cin              carry-in, captured on an accepted start
//   fa_a, fa_b       to the full-adder cell operands (0 outside CALC)
//   fa_cin           to the full-adder cell carry-in (0 outside CALC)
//   fa_sum, fa_cout  from the full-adder cell
//   busy             high while in CALC
//   done             one-cycle pulse, result valid
//   sum_out          registered sum, held until the next result lands
//   cout_out         registered final carry, held with sum_out

module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] din_a,
   input  logic [WIDTH-1:0] din_b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             in_calc;
   logic             last_bit;
   logic [WIDTH-1:0] sum_shifted;

   // sum_sh[0] is always shifted out before it could be read; the final
   // result is assembled from the incoming fa_sum plus the upper bits.
   logic             unused_sum_lsb;

   assign unused_sum_lsb = sum_sh[0];

   assign accept      = (state == ST_IDLE) && start;
   assign in_calc     = (state == ST_CALC);
   assign last_bit    = in_calc && (cnt == CNT_W'(WIDTH - 1));
   assign sum_shifted = {fa_sum, sum_sh[WIDTH-1:1]};

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Next state and state-decoded outputs. busy/done/fa_* depend only
   // on registered state and registers, so they carry no glitches from
   // the requester inputs.
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      fa_a      = 1'b0;
      fa_b      = 1'b0;
      fa_cin    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_CALC;
            end
         end

         ST_CALC: begin
            busy   = 1'b1;
            fa_a   = a_sh[0];
            fa_b   = b_sh[0];
            fa_cin = carry;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nxt = ST_DONE;
            end
         end

         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath: operand shifters, carry, bit counter, result registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         sum_sh   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         if (accept) begin
            a_sh   <= din_a;
            b_sh   <= din_b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
         end else if (in_calc) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
            sum_sh <= sum_shifted;
         end

         // The last bit's sum comes straight from the cell, so the result
         // is complete on this edge rather than one cycle later.
         if (last_bit) begin
            sum_out  <= sum_shifted;
            cout_out <= fa_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl (WIDTH = 8) with a behavioural full-adder
// cell on the fa_* ports and arithmetic reference a + b + cin.

module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] din_a;
   logic [W-1:0] din_b;
   logic         cin;
   logic         fa_a;
   logic         fa_b;
   logic         fa_cin;
   logic         fa_sum;
   logic         fa_cout;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // External full-adder cell
   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .din_a    (din_a),
      .din_b    (din_b),
      .cin      (cin),
      .fa_a     (fa_a),
      .fa_b     (fa_b),
      .fa_cin   (fa_cin),
      .fa_sum   (fa_sum),
      .fa_cout  (fa_cout),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out)
   );

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
      ref_add = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   // Issues one operation from IDLE and measures it; returns at the
   // negedge of the done cycle (or after the cycle budget).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] s, output logic co, output int lat,
                         output int busy_cnt, output logic [W-1:0] a_seq,
                         output logic [W-1:0] b_seq, output bit timeout);
      bit seen;
      seen = 0; s = '0; co = 1'b0; lat = -1; busy_cnt = 0;
      a_seq = '0; b_seq = '0; timeout = 0;
      @(negedge clk);
      din_a = a; din_b = b; cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      din_a = W'($urandom); din_b = W'($urandom); cin = 1'($urandom);
      for (int i = 0; i < 4 * W && !seen; i++) begin
         if (busy) begin
            if (busy_cnt < W) begin
               a_seq[busy_cnt] = fa_a;
               b_seq[busy_cnt] = fa_b;
            end
            busy_cnt++;
         end
         if (done) begin
            seen = 1; s = sum_out; co = cout_out; lat = i;
         end else begin
            @(negedge clk);
         end
      end
      timeout = !seen;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; din_a = '0; din_b = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, cout_out, sum_out, fa_a, fa_b, fa_cin} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h fa=%b%b%b, want all 0",
                  busy, done, cout_out, sum_out, fa_a, fa_b, fa_cin);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_release_idle: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] s, as, bs, a, b;
      logic co, c;
      int lat, bc;
      bit to;
      logic [W:0] exp;
      run_op(8'hFF, 8'h01, 1'b0, s, co, lat, bc, as, bs, to);
      exp = ref_add(8'hFF, 8'h01, 1'b0);
      n_cmp++;
      if (to !== 1'b0 || {co, s} !== exp) begin
         n_err++;
         $display("FAIL basic_ff_01: timeout=%b got %b_%h, want %b_%h", to, co, s, exp[W], exp[W-1:0]);
      end
      n_cmp++;
      if (lat !== W || bc !== W) begin
         n_err++;
         $display("FAIL basic_latency: done after %0d edges busy %0d cycles, want %0d %0d", lat, bc, W, W);
      end
      for (int k = 0; k < 12; k++) begin
         a = W'($urandom); b = W'($urandom); c = 1'($urandom);
         run_op(a, b, c, s, co, lat, bc, as, bs, to);
         exp = ref_add(a, b, c);
         n_cmp++;
         if (to !== 1'b0 || {co, s} !== exp || lat !== W) begin
            n_err++;
            $display("FAIL random_add %h+%h+%b: timeout=%b lat=%0d got %b_%h, want lat %0d %b_%h",
                     a, b, c, to, lat, co, s, W, exp[W], exp[W-1:0]);
         end
      end
   endtask

   task automatic test_fa_sequence();
      logic [W-1:0] s, as, bs;
      logic co;
      int lat, bc;
      bit to;
      logic [W:0] exp;
      run_op(8'hA5, 8'h5A, 1'b1, s, co, lat, bc, as, bs, to);
      exp = ref_add(8'hA5, 8'h5A, 1'b1);
      n_cmp++;
      if (to !== 1'b0 || {co, s} !== exp) begin
         n_err++;
         $display("FAIL a5_5a_result: got %b_%h, want %b_%h", co, s, exp[W], exp[W-1:0]);
      end
      n_cmp++;
      if (as !== 8'hA5 || bs !== 8'h5A) begin
         n_err++;
         $display("FAIL fa_bit_order: fa_a seq %b fa_b seq %b (bit i = cycle i), want %b %b",
                  as, bs, 8'hA5, 8'h5A);
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] s, as, bs;
      logic co;
      int lat, bc;
      bit to;
      logic [W:0] exp;
      run_op(8'h00, 8'h00, 1'b1, s, co, lat, bc, as, bs, to);
      exp = ref_add(8'h00, 8'h00, 1'b1);
      n_cmp++;
      if (to !== 1'b0 || {co, s} !== exp) begin
         n_err++;
         $display("FAIL zero_plus_cin: got %b_%h, want %b_%h", co, s, exp[W], exp[W-1:0]);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({done, busy, cout_out, sum_out} !== {2'b00, exp}) begin
            n_err++;
            $display("FAIL hold_idle[%0d]: done=%b busy=%b result %b_%h, want 0 0 %b_%h",
                     i, done, busy, cout_out, sum_out, exp[W], exp[W-1:0]);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] a, b, s;
      logic c, co;
      int done_cnt;
      logic [W:0] exp;
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      exp = ref_add(a, b, c);
      s = '0; co = 1'b0; done_cnt = 0;
      @(negedge clk);
      din_a = a; din_b = b; cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < W + 15; i++) begin
         if (done) begin
            done_cnt++; s = sum_out; co = cout_out;
         end
         if (i == 3) begin
            din_a = ~a; din_b = ~b; cin = ~c; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_start_pulses: done pulses %0d busy=%b, want 1 0", done_cnt, busy);
      end
      n_cmp++;
      if ({co, s} !== exp) begin
         n_err++;
         $display("FAIL ignore_start_result: got %b_%h, want %b_%h", co, s, exp[W], exp[W-1:0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] s, as, bs, a, b;
      logic co, c;
      int lat, bc, done_cnt;
      bit to;
      logic [W:0] exp;
      run_op(8'h12, 8'h34, 1'b0, s, co, lat, bc, as, bs, to);
      exp = ref_add(8'h12, 8'h34, 1'b0);
      n_cmp++;
      if (to !== 1'b0 || {co, s} !== exp) begin
         n_err++;
         $display("FAIL pre_reset_result: got %b_%h, want %b_%h", co, s, exp[W], exp[W-1:0]);
      end
      @(negedge clk);
      din_a = 8'hC3; din_b = 8'h7E; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL busy_at_bit4: busy=%b, want 1", busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if ({busy, done, cout_out, sum_out, fa_a, fa_b, fa_cin} !== '0) begin
         n_err++;
         $display("FAIL mid_reset_clear: busy=%b done=%b cout=%b sum=%h fa=%b%b%b, want all 0",
                  busy, done, cout_out, sum_out, fa_a, fa_b, fa_cin);
      end
      done_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      n_cmp++;
      if (done_cnt !== 0) begin
         n_err++;
         $display("FAIL mid_reset_no_done: %0d cycles with busy/done after reset, want 0", done_cnt);
      end
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      run_op(a, b, c, s, co, lat, bc, as, bs, to);
      exp = ref_add(a, b, c);
      n_cmp++;
      if (to !== 1'b0 || {co, s} !== exp || lat !== W) begin
         n_err++;
         $display("FAIL post_reset_add %h+%h+%b: timeout=%b lat=%0d got %b_%h, want lat %0d %b_%h",
                  a, b, c, to, lat, co, s, W, exp[W], exp[W-1:0]);
      end
   endtask

   task automatic test_back_to_back();
      int times[8];
      logic [W-1:0] sums[8];
      logic couts[8];
      int n_done;
      bit drained;
      logic [W:0] exp;
      exp = ref_add(8'h10, 8'h20, 1'b0);
      n_done = 0;
      @(negedge clk);
      din_a = 8'h10; din_b = 8'h20; cin = 1'b0; start = 1'b1;
      for (int i = -1; i < 45; i++) begin
         @(negedge clk);
         if (done && n_done < 8) begin
            times[n_done] = i + 1; sums[n_done] = sum_out; couts[n_done] = cout_out;
            n_done++;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (n_done !== 4 || times[0] !== W) begin
         n_err++;
         $display("FAIL b2b_count: %0d pulses first at %0d, want 4 first at %0d",
                  n_done, times[0], W);
      end
      for (int k = 0; k < n_done && k < 8; k++) begin
         n_cmp++;
         if ({couts[k], sums[k]} !== exp) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: got %b_%h, want %b_%h", k, couts[k], sums[k],
                     exp[W], exp[W-1:0]);
         end
         if (k > 0) begin
            n_cmp++;
            if (times[k] - times[k-1] !== W + 2) begin
               n_err++;
               $display("FAIL b2b_interval[%0d]: %0d cycles, want %0d", k,
                        times[k] - times[k-1], W + 2);
            end
         end
      end
      drained = 0;
      for (int i = 0; i < 4 * W && !drained; i++) begin
         @(negedge clk);
         if (!busy && !done) drained = 1;
      end
      n_cmp++;
      if (!drained) begin
         n_err++;
         $display("FAIL b2b_drain: busy=%b done=%b still active, want idle", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fa_sequence();
      test_hold();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add controller that sequences the single-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock.
- Sits between a requester (start/done handshake) and one external full-adder cell. It drives that cell's a/b/cin inputs and consumes its sum/cout.
- Trades WIDTH+1 cycles of latency for one adder cell instead of a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits (valid range 2..32).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- din_a  input  WIDTH  operand A; captured on accepted start.
- din_b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- fa_a  output  1  to full-adder operand 1.
- fa_b  output  1  to full-adder operand 2.
- fa_cin  output  1  to full-adder carry-in.
- fa_sum  input  1  from full-adder sum.
- fa_cout  input  1  from full-adder carry-out.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse, result valid.
- sum_out  output  WIDTH  registered sum; held until next accepted start.
- cout_out  output  1  registered final carry; held until next accepted start.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset value (rst_n low at a clock edge):
  - state = IDLE.
  - Shift registers, carry register and counter = 0.
  - busy = 0, done = 0, sum_out = 0, cout_out = 0.
  - Reset overrides everything. An operation in progress is discarded with no done pulse.
- FSM states: IDLE, CALC, DONE.
  - IDLE: if start = 1 at an edge, load a_sh <= din_a, b_sh <= din_b, carry <= cin, cnt <= 0, sum_sh <= 0, and go to CALC. Otherwise stay in IDLE.
  - CALC: the cell inputs are combinational from registers: fa_a = a_sh[0], fa_b = b_sh[0], fa_cin = carry. At each edge:
    - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right, zero-filled.
    - carry <= fa_cout.
    - cnt <= cnt + 1.
    - When cnt == WIDTH-1: sum_out <= {fa_sum, sum_sh[WIDTH-1:1]}, cout_out <= fa_cout, go to DONE.
  - DONE: done = 1 for exactly this cycle, then unconditionally return to IDLE.
- Outputs by state:
  - fa_a, fa_b and fa_cin are 0 in IDLE and DONE.
  - busy = (state == CALC); done = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- Latency and throughput:
  - If start is sampled at edge k, CALC spans edges k+1 .. k+WIDTH.
  - done is high in the cycle after edge k+WIDTH, and sum_out/cout_out are valid in that same cycle.
  - Minimum issue interval is WIDTH+2 cycles (CALC x WIDTH, DONE, IDLE).
- Handshake rules:
  - start is ignored in CALC and DONE. It is not queued.
  - din_a, din_b and cin may change freely after the accepting edge.
  - start held high continuously re-triggers in each IDLE cycle.
- Arithmetic: {cout_out, sum_out} = din_a + din_b + cin, modulo 2^(WIDTH+1). There are no overflow flags.
- Reset mid-CALC: the next cycle is IDLE, all outputs are 0, and the previous sum_out is cleared.

Test Plan (WIDTH=8, behavioural full-adder model on fa_* ports):
- din_a=0xFF, din_b=0x01, cin=0, start 1 cycle -> busy for 8 cycles; done pulse 8 cycles after the accepting edge; sum_out=0x00, cout_out=1.
- din_a=0xA5, din_b=0x5A, cin=1 -> sum_out=0x00, cout_out=1. fa_a sequence LSB first is 1,0,1,0,0,1,0,1.
- din_a=0x00, din_b=0x00, cin=1 -> sum_out=0x01, cout_out=0. Results hold through 20 idle cycles with no start.
- Start pulsed mid-CALC with different operands -> ignored. The first result is unchanged and exactly one done pulse occurs.
- rst_n low for 1 cycle at CALC bit 4 -> IDLE next cycle; busy=0, sum_out=0x00, no done pulse. A following start then completes correctly.
- start held high with din_a=0x10, din_b=0x20, cin=0 -> done pulses every 10 cycles, sum_out=0x30 each time.
